// File: rtl/priority_encoder.sv
// Registered priority encoder: index, one-hot mask and valid flag of the
// winning request bit, one clock after sampling.
module priority_encoder #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned YW        = $clog2(WIDTH),
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    output logic [YW-1:0]    y,
    output logic             valid,
    output logic [WIDTH-1:0] onehot
);

    logic [YW-1:0]    y_d, y_q;
    logic             valid_d, valid_q;
    logic [WIDTH-1:0] onehot_d, onehot_q;
    logic [YW-1:0]    idx;

    // Scan from lowest to highest priority; the last hit seen is the winner.
    always_comb begin
        y_d      = '0;
        valid_d  = 1'b0;
        onehot_d = '0;
        idx      = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            idx = MSB_FIRST ? YW'(i) : YW'(WIDTH - 1 - i);
            if (a[idx]) begin
                y_d           = idx;
                valid_d       = 1'b1;
                onehot_d      = '0;
                onehot_d[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q      <= '0;
            valid_q  <= 1'b0;
            onehot_q <= '0;
        end else begin
            y_q      <= y_d;
            valid_q  <= valid_d;
            onehot_q <= onehot_d;
        end
    end

    assign y      = y_q;
    assign valid  = valid_q;
    assign onehot = onehot_q;

endmodule

// File: tb/tb_priority_encoder.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor
// pops and compares one cycle later for MSB-first, LSB-first and WIDTH=5 DUTs.
module tb_priority_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] a8;
    logic [4:0] a5;

    logic [2:0] y_m, y_l, y_5;
    logic       v_m, v_l, v_5;
    logic [7:0] oh_m, oh_l;
    logic [4:0] oh_5;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] ym;
        logic [7:0] ohm;
        logic [2:0] yl;
        logic [7:0] ohl;
        logic       v;
        logic [2:0] y5;
        logic [4:0] oh5;
        logic       v5;
    } exp_t;

    exp_t q[$];

    priority_encoder #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .a(a8), .y(y_m), .valid(v_m), .onehot(oh_m)
    );
    priority_encoder #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .a(a8), .y(y_l), .valid(v_l), .onehot(oh_l)
    );
    priority_encoder #(.WIDTH(5), .MSB_FIRST(1'b1)) u_w5 (
        .clk(clk), .rst_n(rst_n), .a(a5), .y(y_5), .valid(v_5), .onehot(oh_5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " y_m"}, 64'(y_m), 64'd0);
        chk({tag, " v_m"}, 64'(v_m), 64'd0);
        chk({tag, " oh_m"}, 64'(oh_m), 64'd0);
        chk({tag, " y_l"}, 64'(y_l), 64'd0);
        chk({tag, " v_l"}, 64'(v_l), 64'd0);
        chk({tag, " oh_l"}, 64'(oh_l), 64'd0);
        chk({tag, " y_5"}, 64'(y_5), 64'd0);
        chk({tag, " v_5"}, 64'(v_5), 64'd0);
        chk({tag, " oh_5"}, 64'(oh_5), 64'd0);
    endtask

    // Monitor: outputs are presented every cycle, so one expectation per edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            chk("msb y", 64'(y_m), 64'(e.ym));
            chk("msb onehot", 64'(oh_m), 64'(e.ohm));
            chk("msb valid", 64'(v_m), 64'(e.v));
            chk("lsb y", 64'(y_l), 64'(e.yl));
            chk("lsb onehot", 64'(oh_l), 64'(e.ohl));
            chk("lsb valid", 64'(v_l), 64'(e.v));
            chk("w5 y", 64'(y_5), 64'(e.y5));
            chk("w5 onehot", 64'(oh_5), 64'(e.oh5));
            chk("w5 valid", 64'(v_5), 64'(e.v5));
        end
    end

    task automatic drive(input logic [7:0] v8, input logic [4:0] v5_in,
                         input logic [2:0] ym, input logic [7:0] ohm,
                         input logic [2:0] yl, input logic [7:0] ohl,
                         input logic v,
                         input logic [2:0] y5, input logic [4:0] oh5, input logic v5);
        exp_t e;
        @(negedge clk);
        a8 = v8;
        a5 = v5_in;
        e.ym = ym; e.ohm = ohm; e.yl = yl; e.ohl = ohl; e.v = v;
        e.y5 = y5; e.oh5 = oh5; e.v5 = v5;
        q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0;
        a8    = 8'hFF;
        a5    = 5'h1F;
        #1;
        chk_zero("reset t0");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_zero("reset held");
        end

        // Release with all ones still applied
        @(negedge clk);
        rst_n = 1'b1;
        begin
            exp_t e;
            e.ym = 3'd7; e.ohm = 8'h80; e.yl = 3'd0; e.ohl = 8'h01; e.v = 1'b1;
            e.y5 = 3'd4; e.oh5 = 5'h10; e.v5 = 1'b1;
            q.push_back(e);
        end

        //     a8     a5     ym    ohm     yl    ohl    v     y5    oh5    v5
        drive(8'h06, 5'h1F, 3'd2, 8'h04, 3'd1, 8'h02, 1'b1, 3'd4, 5'h10, 1'b1);
        drive(8'h05, 5'h00, 3'd2, 8'h04, 3'd0, 8'h01, 1'b1, 3'd0, 5'h00, 1'b0);
        drive(8'h08, 5'h06, 3'd3, 8'h08, 3'd3, 8'h08, 1'b1, 3'd2, 5'h04, 1'b1);
        drive(8'h02, 5'h11, 3'd1, 8'h02, 3'd1, 8'h02, 1'b1, 3'd4, 5'h10, 1'b1);
        drive(8'h00, 5'h01, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 5'h01, 1'b1);
        drive(8'h03, 5'h08, 3'd1, 8'h02, 3'd0, 8'h01, 1'b1, 3'd3, 5'h08, 1'b1);
        drive(8'h07, 5'h0A, 3'd2, 8'h04, 3'd0, 8'h01, 1'b1, 3'd3, 5'h08, 1'b1);
        drive(8'hFF, 5'h10, 3'd7, 8'h80, 3'd0, 8'h01, 1'b1, 3'd4, 5'h10, 1'b1);
        drive(8'h80, 5'h00, 3'd7, 8'h80, 3'd7, 8'h80, 1'b1, 3'd0, 5'h00, 1'b0);

        // Walking one
        for (int i = 0; i < 8; i++) begin
            if (i < 5)
                drive(8'(1 << i), 5'(1 << i), 3'(i), 8'(1 << i), 3'(i), 8'(1 << i), 1'b1,
                      3'(i), 5'(1 << i), 1'b1);
            else
                drive(8'(1 << i), 5'h00, 3'(i), 8'(1 << i), 3'(i), 8'(1 << i), 1'b1,
                      3'd0, 5'h00, 1'b0);
        end

        // Asynchronous reset between edges while valid is high
        drive(8'h24, 5'h03, 3'd5, 8'h20, 3'd2, 8'h04, 1'b1, 3'd1, 5'h02, 1'b1);
        @(posedge clk);
        #3;
        chk("pre-reset valid", 64'(v_m), 64'd1);
        rst_n = 1'b0;
        q.delete();
        #1;
        chk_zero("async reset");

        @(negedge clk);
        chk_zero("reset edge");
        rst_n = 1'b1;
        a8 = 8'h41;
        a5 = 5'h0C;
        begin
            exp_t e;
            e.ym = 3'd6; e.ohm = 8'h40; e.yl = 3'd0; e.ohl = 8'h01; e.v = 1'b1;
            e.y5 = 3'd3; e.oh5 = 5'h08; e.v5 = 1'b1;
            q.push_back(e);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard drained", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
